// File: rtl/tdc_record_uart_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_record_uart_if
//  Description : Record capture bus from the CAN TDC measurement block.
//                The master drives a 27-bit record and its capture strobe.
//                The slave (tdc_record_uart) samples both signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface tdc_record_uart_if;
    logic [26:0] in_data;
    logic        write_request;

    modport master (output in_data, output write_request);
    modport slave  (input  in_data, input  write_request);
endinterface
`default_nettype wire

// File: rtl/tdc_record_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_record_uart
//  Description : Buffers 27-bit TDC records in a FIFO and streams each record
//                to the host as a framed UART 8N1 packet.
//                Packet bytes: SYNC_BYTE, {5'b0,d[26:24]}, d[23:16], d[15:8],
//                d[7:0].
//                Optional macro TDC_UART_CHECKSUM_EN appends a sixth byte,
//                the XOR of bytes 1..4.
//  Revision    : 1.0  initial release
// ============================================================================
module tdc_record_uart #(
    parameter int         ADDR_W    = 4,
    parameter int         BAUD_DIV  = 434,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic             CLK,
    input  logic             RST_N,
    tdc_record_uart_if.slave rec,
    input  logic             clear_overflow,
    output logic             uart_tx,
    output logic             busy,
    output logic [ADDR_W:0]  fifo_level,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int                 C_DEPTH    = 1 << ADDR_W;
    localparam int                 C_TMR_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(BAUD_DIV - 1);
`ifdef TDC_UART_CHECKSUM_EN
    localparam logic [2:0]         C_LAST_BYTE = 3'd5;
`else
    localparam logic [2:0]         C_LAST_BYTE = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Capture side
    logic               r_wr_prev;
    logic [26:0]        r_mem [C_DEPTH];
    logic [ADDR_W:0]    r_wptr;
    logic [ADDR_W:0]    r_rptr;
    logic               r_overflow;
    logic [7:0]         r_drop_count;
    logic               w_push_edge;
    logic               w_push;
    logic               w_drop;
    logic               w_empty;
    logic               w_full;

    // Transmit side
    state_t             r_state;
    state_t             w_state_nxt;
    logic [26:0]        r_shadow;
    logic [C_TMR_W-1:0] r_tmr;
    logic [C_TMR_W-1:0] w_tmr_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_nxt;
    logic [2:0]         r_byte_idx;
    logic [2:0]         w_byte_nxt;
    logic               r_uart_tx;
    logic               w_tx_nxt;
    logic               w_pop;
    logic               w_tmr_done;
    logic [7:0]         w_cur_byte;
`ifdef TDC_UART_CHECKSUM_EN
    logic [7:0]         w_checksum;
`endif

    assign w_push_edge = rec.write_request & ~r_wr_prev;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                         (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    // A full FIFO still accepts a record when a slot frees in the same cycle
    assign w_push      = w_push_edge & (~w_full | w_pop);
    assign w_drop      = w_push_edge & ~w_push;
    assign w_tmr_done  = (r_tmr == C_TMR_LAST);

    // Previous strobe level, so a held strobe yields exactly one push
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_wr_prev <= 1'b0;
        else        r_wr_prev <= rec.write_request;
    end

    // Record storage; validity is defined by the pointers, so no reset needed
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr[ADDR_W-1:0]] <= rec.in_data;
    end

    // Wrap-around read/write pointers with an extra MSB for full/empty
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (ADDR_W+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (ADDR_W+1)'(1);
        end
    end

    // Sticky overflow flag and saturating drop counter; clear has priority
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // Shadow copy of the record being transmitted, loaded on pop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     r_shadow <= '0;
        else if (w_pop) r_shadow <= r_mem[r_rptr[ADDR_W-1:0]];
    end

`ifdef TDC_UART_CHECKSUM_EN
    assign w_checksum = {5'b0, r_shadow[26:24]} ^ r_shadow[23:16] ^
                        r_shadow[15:8] ^ r_shadow[7:0];
`endif

    // Select the packet byte currently being serialised
    always_comb begin
        w_cur_byte = SYNC_BYTE;
        case (r_byte_idx)
            3'd0:    w_cur_byte = SYNC_BYTE;
            3'd1:    w_cur_byte = {5'b0, r_shadow[26:24]};
            3'd2:    w_cur_byte = r_shadow[23:16];
            3'd3:    w_cur_byte = r_shadow[15:8];
            3'd4:    w_cur_byte = r_shadow[7:0];
`ifdef TDC_UART_CHECKSUM_EN
            3'd5:    w_cur_byte = w_checksum;
`endif
            default: w_cur_byte = SYNC_BYTE;
        endcase
    end

    // TX state register plus bit timer, indices and a glitch-free line driver
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_uart_tx  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_uart_tx  <= w_tx_nxt;
        end
    end

    // TX next-state, pop request and next line level
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + C_TMR_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_byte_nxt  = 3'd0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tmr_done) begin
                    w_tmr_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tmr_done) begin
                    w_tmr_nxt = '0;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                    else                   w_bit_nxt   = r_bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (w_tmr_done) begin
                    w_tmr_nxt = '0;
                    if (r_byte_idx == C_LAST_BYTE) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_nxt  = r_byte_idx + 3'd1;
                        w_state_nxt = S_START;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Byte index is stable across START->DATA and DATA->DATA transitions
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign uart_tx    = r_uart_tx;
    assign busy       = (r_state != S_IDLE) | w_pop;
    assign fifo_level = r_wptr - r_rptr;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_tdc_record_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_record_uart
//  Description : Self-checking bench for tdc_record_uart (ADDR_W=2,
//                BAUD_DIV=4). A queue-based packet model predicts the line,
//                busy, level and drop outputs every cycle; directed tests add
//                literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdc_record_uart;
    localparam int ADDR_W   = 2;
    localparam int BAUD_DIV = 4;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef TDC_UART_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif
    localparam int PKT = NBYTES * 10 * BAUD_DIV;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              clear_overflow = 1'b0;
    logic              uart_tx;
    logic              busy;
    logic [ADDR_W:0]   fifo_level;
    logic              overflow;
    logic [7:0]        drop_count;

    tdc_record_uart_if rec_if();

    tdc_record_uart #(.ADDR_W(ADDR_W), .BAUD_DIV(BAUD_DIV), .SYNC_BYTE(8'hA5)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .rec            (rec_if),
        .clear_overflow (clear_overflow),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [26:0] m_q [$];
    logic        m_prev;
    logic        m_inflight;
    logic [26:0] m_rec;
    int          m_t;
    logic        m_ovf;
    int          m_drops;

    function automatic logic [7:0] pkt_byte(input logic [26:0] d, input int i);
        logic [7:0] b1, b2, b3, b4;
        b1 = {5'b0, d[26:24]};
        b2 = d[23:16];
        b3 = d[15:8];
        b4 = d[7:0];
        case (i)
            0:       return 8'hA5;
            1:       return b1;
            2:       return b2;
            3:       return b3;
            4:       return b4;
            5:       return b1 ^ b2 ^ b3 ^ b4;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic line_bit(input logic [26:0] d, input int t);
        int         bidx;
        int         slot;
        logic [7:0] b;
        bidx = t / (10 * BAUD_DIV);
        slot = (t % (10 * BAUD_DIV)) / BAUD_DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        b = pkt_byte(d, bidx);
        return b[slot-1];
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_prev     = 1'b0;
        m_inflight = 1'b0;
        m_rec      = '0;
        m_t        = 0;
        m_ovf      = 1'b0;
        m_drops    = 0;
    endtask

    task automatic m_step();
        logic e_push;
        logic pop;
        logic drop;
        int   sz;
        e_push = rec_if.write_request && !m_prev;
        m_prev = rec_if.write_request;
        sz     = m_q.size();
        pop    = !m_inflight && (sz > 0);
        drop   = 1'b0;
        if (m_inflight) begin
            m_t++;
            if (m_t == PKT) m_inflight = 1'b0;
        end
        if (pop) begin
            m_rec      = m_q.pop_front();
            m_inflight = 1'b1;
            m_t        = 0;
        end
        if (e_push) begin
            if (sz < DEPTH || pop) m_q.push_back(rec_if.in_data);
            else                   drop = 1'b1;
        end
        if (clear_overflow) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) m_reset();
            else        m_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                chk("cyc_uart_tx", 32'(uart_tx), 32'(m_inflight ? line_bit(m_rec, m_t) : 1'b1));
                chk("cyc_busy", 32'(busy), 32'(m_inflight || (m_q.size() > 0)));
                chk("cyc_fifo_level", 32'(fifo_level), 32'(m_q.size()));
                chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
                chk("cyc_drop_count", 32'(drop_count), 32'(m_drops));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [26:0] d);
        rec_if.in_data       = d;
        rec_if.write_request = 1'b1;
        tick();
        rec_if.write_request = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < bound);
        chk(name, 32'(busy), 32'd0);
        tick();
    endtask

    logic            tx_s   [0:PKT+2];
    logic            busy_s [0:PKT+2];
    logic [ADDR_W:0] lvl_s  [0:PKT+2];
    logic [7:0]      exp_b  [0:5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W:0] peak;
        logic [7:0]      rx;
        logic            found;
        logic            quiet;
        int              k;

        exp_b[0] = 8'hA5; exp_b[1] = 8'h01; exp_b[2] = 8'h23;
        exp_b[3] = 8'h0A; exp_b[4] = 8'h08; exp_b[5] = 8'h20;
        rec_if.in_data       = '0;
        rec_if.write_request = 1'b0;

        // Reset values, during and right after reset
        repeat (3) @(negedge CLK);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        tick();
        RST_N = 1'b1;
        repeat (3) tick();

        // Single record: A5,01,23,0A,08 (+20 with checksum)
        rec_if.in_data       = 27'h1230A08;
        rec_if.write_request = 1'b1;
        for (k = 0; k < PKT + 3; k++) begin
            @(negedge CLK);
            tx_s[k]   = uart_tx;
            busy_s[k] = busy;
            lvl_s[k]  = fifo_level;
            if (k == 1) rec_if.write_request = 1'b0;
        end
        chk("single_level_n1", 32'(lvl_s[1]), 32'd1);
        chk("single_tx_n1_idle", 32'(tx_s[1]), 32'd1);
        chk("single_start_n2", 32'(tx_s[2]), 32'd0);
        chk("single_level_n2", 32'(lvl_s[2]), 32'd0);
        for (int i = 0; i < NBYTES; i++) begin
            for (int j = 0; j < 8; j++)
                rx[j] = tx_s[2 + i*10*BAUD_DIV + (1+j)*BAUD_DIV + BAUD_DIV/2];
            chk("single_start_bit", 32'(tx_s[2 + i*10*BAUD_DIV + BAUD_DIV/2]), 32'd0);
            chk("single_byte", 32'(rx), 32'(exp_b[i]));
            chk("single_stop_bit", 32'(tx_s[2 + i*10*BAUD_DIV + 9*BAUD_DIV + BAUD_DIV/2]), 32'd1);
        end
        chk("single_busy_last", 32'(busy_s[PKT+1]), 32'd1);
        chk("single_busy_after", 32'(busy_s[PKT+2]), 32'd0);
        tick();

        // Held strobe: exactly one push
        rec_if.in_data       = 27'h5A5A5A5;
        rec_if.write_request = 1'b1;
        peak = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge CLK);
            if (fifo_level > peak) peak = fifo_level;
            if (n == 9) rec_if.write_request = 1'b0;
        end
        chk("held_peak_level", 32'(peak), 32'd1);
        wait_idle("held_idle_timeout", 3 * PKT);

        // Overflow: 6 edges two cycles apart, one dropped
        for (int i = 0; i < 6; i++) begin
            pulse(27'h1000000 + 27'(i) * 27'h0111111);
            tick();
        end
        @(negedge CLK);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        tick();

        // Full FIFO plus push in the pop cycle: accepted, no drop
        found = 1'b0;
        for (int n = 0; n < 2 * PKT && !found; n++) begin
            tick();
            if (!m_inflight && m_q.size() == DEPTH) begin
                pulse(27'h7654321);
                found = 1'b1;
            end
        end
        chk("fullpop_found", 32'(found), 32'd1);
        @(negedge CLK);
        chk("fullpop_level", 32'(fifo_level), 32'd4);
        chk("fullpop_drop_count", 32'(drop_count), 32'd1);
        tick();

        // Saturation of the drop counter
        for (int i = 0; i < 310; i++) begin
            pulse(27'h0000100 + 27'(i));
            tick();
        end
        @(negedge CLK);
        chk("sat_drop_count", 32'(drop_count), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        tick();

        // Clear coincident with a drop
        found = 1'b0;
        for (int n = 0; n < 2 * PKT && !found; n++) begin
            tick();
            if (m_inflight && m_t < PKT - 3) begin
                if (m_q.size() == DEPTH) begin
                    clear_overflow = 1'b1;
                    pulse(27'h3333333);
                    clear_overflow = 1'b0;
                    found = 1'b1;
                end else begin
                    pulse(27'h2222222);
                end
            end
        end
        chk("clear_found", 32'(found), 32'd1);
        @(negedge CLK);
        chk("clear_overflow", 32'(overflow), 32'd0);
        chk("clear_drop_count", 32'(drop_count), 32'd0);
        tick();

        // Reset during B2 start bit
        found = 1'b0;
        for (int n = 0; n < 2 * PKT && !found; n++) begin
            tick();
            if (m_inflight && m_t == 20 * BAUD_DIV + 1) found = 1'b1;
        end
        chk("rstmid_found", 32'(found), 32'd1);
        #1;
        chk("rstmid_pre_tx", 32'(uart_tx), 32'd0);
        RST_N = 1'b0;
        #1;
        chk("rstmid_tx", 32'(uart_tx), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_level", 32'(fifo_level), 32'd0);
        repeat (3) tick();
        RST_N = 1'b1;
        quiet = 1'b1;
        for (int n = 0; n < 3 * PKT; n++) begin
            @(negedge CLK);
            if (!uart_tx || busy || fifo_level != '0) quiet = 1'b0;
        end
        chk("rstmid_quiet", 32'(quiet), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdc_record_uart.md
# tdc_record_uart

Downstream stage of the CAN TDC measurement block: captures each 27-bit record `{CAN_ID[10:0], measure_time[11:0], DLC[3:0]}` on its `write_request` strobe. Records are buffered in an internal FIFO and streamed to the host PC as fixed-length framed UART 8N1 packets. Sits between the measurement block and the board's UART TX pin, and decouples CAN frame rate from host link rate.

## Interface
- `ADDR_W`, 4: FIFO address width; depth = 2^ADDR_W records.
- `BAUD_DIV`, 434: CLK cycles per UART bit (50 MHz / 115200).
- `SYNC_BYTE`, 8'hA5: first byte of every packet.

- `CLK`  in  1  system clock, 50 MHz; all logic on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `in_data`  in  27  record from measurement block; valid in the cycle `write_request` rises.
- `write_request`  in  1  capture strobe, `CLK` domain; level may persist more than one cycle.
- `clear_overflow`  in  1  synchronous clear of `overflow` and `drop_count`.
- `uart_tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a packet is on the line.
- `fifo_level`  out  ADDR_W+1  records currently stored (0..2^ADDR_W).
- `overflow`  out  1  sticky; set when a record is dropped.
- `drop_count`  out  8  dropped records, saturates at 255.

## Operation
- **Capture**
  - Push on rising edge of `write_request` (registered previous value 0, current 1); one push per edge regardless of pulse length.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped, `overflow` <= 1 and `drop_count` increments (saturating).
- **Clear:** `clear_overflow` wins over a simultaneous drop; both outputs read 0 next cycle.
- **FIFO:** circular buffer with wrap-around pointers of ADDR_W+1 bits. Full means pointers are equal except for the MSB.
- **Packet:** B0=SYNC_BYTE, B1={5'b0,d[26:24]}, B2=d[23:16], B3=d[15:8], B4=d[7:0]. Each byte is start(0), 8 data bits LSB first, stop(1).
- **TX FSM states:**
  - IDLE: `uart_tx`=1. If FIFO is non-empty, pop, latch the record into a shadow register, byte_idx=0, go to START.
  - START: drive 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bits, BAUD_DIV cycles each, then go to STOP.
  - STOP: drive 1 for BAUD_DIV cycles. If this was the last byte, go to IDLE; otherwise byte_idx++ and go to START.
- **`busy`:** 1 in START, DATA and STOP; 1 in IDLE only in the pop cycle.
- **Bit timer:** counts 0..BAUD_DIV-1 and is reloaded on every state entry.

## Timing
- **Reset values:** `uart_tx`=1, `busy`=0, `fifo_level`=0, `overflow`=0, `drop_count`=0, FSM=IDLE, pointers=0.
- **Reset mid-packet:** the line returns high asynchronously and the in-flight record plus all FIFO contents are discarded.
- **Latency, push into an empty idle block:**
  - Edge seen at cycle N.
  - `fifo_level`=1 at N+1.
  - Pop at N+1; `fifo_level`=0 at N+2.
  - `uart_tx` falls at N+2.
- **Packet length:** 5×10×BAUD_DIV cycles (6× with checksum).
- **Back-to-back packets:** the next start bit begins exactly 1 cycle after the previous final stop bit ends (the IDLE pop cycle).
- **`fifo_level`:** updates one cycle after push or pop. Push and pop in the same cycle leave it unchanged.

## Configuration
- **`TDC_UART_CHECKSUM_EN` defined:** a sixth byte B5 = B1^B2^B3^B4 is appended after B4, with identical framing.
- **Undefined:** packets are 5 bytes and no checksum logic is built.

## Test plan
- **Single record:** `in_data`=0x1230A08 (ID 0x123, time 160, DLC 8) -> line carries A5,01,23,0A,08 LSB-first. Start bit at edge+2 cycles; `busy` low after 50×434 cycles. With the macro defined, an extra byte 0x20 is sent.
- **Held strobe:** `write_request` held high 10 cycles -> exactly one push, `fifo_level` peaks at 1.
- **Overflow, ADDR_W=2:** 6 edges 2 cycles apart while idle -> first record popped immediately, 4 buffered, 1 dropped. Result: `overflow`=1, `drop_count`=1, then 5 packets in push order.
- **Full plus simultaneous pop:** FIFO full, push edge in the IDLE pop cycle -> accepted, `fifo_level` stays 2^ADDR_W, no drop.
- **Clear and saturation:** 300 drops -> `drop_count`=255. Then `clear_overflow` coincident with a drop -> `overflow`=0, `drop_count`=0.
- **Reset mid-packet:** `RST_N` low during B2 -> `uart_tx`=1 immediately. After release, FIFO is empty and no transmission occurs until a new edge.
